// File: rtl/routing_table_prog_if.sv
`default_nettype none
// ============================================================================
// Module      : routing_table_prog_if
// Description : Config-write and lookup signal bundle for routing_table_prog.
// Revision    : 1.0 - initial release
// ============================================================================
interface routing_table_prog_if #(
  parameter int XW = 3,
  parameter int YW = 2,
  parameter int PW = 3
);
  logic          init_req;
  logic          rdy;
  logic          cfg_we;
  logic [XW-1:0] cfg_xpos;
  logic [YW-1:0] cfg_ypos;
  logic [PW-1:0] cfg_port;
  logic          cfg_ack;
  logic          cfg_err;
  logic          lk_valid;
  logic [XW-1:0] lk_xpos;
  logic [YW-1:0] lk_ypos;
  logic          lk_out_valid;
  logic [PW-1:0] lk_port;
  logic          lk_err;

  modport master (
    output init_req, cfg_we, cfg_xpos, cfg_ypos, cfg_port,
    output lk_valid, lk_xpos, lk_ypos,
    input  rdy, cfg_ack, cfg_err, lk_out_valid, lk_port, lk_err
  );

  modport slave (
    input  init_req, cfg_we, cfg_xpos, cfg_ypos, cfg_port,
    input  lk_valid, lk_xpos, lk_ypos,
    output rdy, cfg_ack, cfg_err, lk_out_valid, lk_port, lk_err
  );
endinterface
`default_nettype wire

// File: rtl/routing_table_prog.sv
`default_nettype none
// ============================================================================
// Module      : routing_table_prog
// Description : Runtime-programmable mesh routing table, self-loaded with YX
//               default routes after reset or on request; registered lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module routing_table_prog #(
  parameter int XDIM    = 5,
  parameter int YDIM    = 4,
  parameter int XW      = 3,
  parameter int YW      = 2,
  parameter int PW      = 3,
  parameter int MY_XPOS = 0,
  parameter int MY_YPOS = 0
) (
  input  wire logic             clk,
  input  wire logic             rst,
  routing_table_prog_if.slave   bus
);

  localparam int N  = XDIM * YDIM;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [PW-1:0] PORT_NEG_Y   = PW'(0);
  localparam logic [PW-1:0] PORT_POS_X   = PW'(1);
  localparam logic [PW-1:0] PORT_POS_Y   = PW'(2);
  localparam logic [PW-1:0] PORT_NEG_X   = PW'(3);
  localparam logic [PW-1:0] PORT_LOCAL   = PW'(4);
  localparam logic [PW-1:0] PORT_INVALID = PW'(7);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    r_state;
  logic [XW-1:0] r_init_x;
  logic [YW-1:0] r_init_y;
  logic [PW-1:0] r_table [N];

  logic          r_cfg_ack;
  logic          r_cfg_err;
  logic          r_lk_out_valid;
  logic [PW-1:0] r_lk_port;
  logic          r_lk_err;

  logic          w_rdy;
  logic          w_init_last;
  logic          w_cfg_in_range;
  logic          w_lk_in_range;
  logic          w_cfg_accept;
  logic [IW-1:0] w_init_idx;
  logic [IW-1:0] w_cfg_idx;
  logic [IW-1:0] w_lk_idx;

  // Column-major flattening: x selects a block of YDIM consecutive entries.
  function automatic logic [IW-1:0] entry_idx(input logic [XW-1:0] x,
                                              input logic [YW-1:0] y);
    return IW'(int'(x) * YDIM + int'(y));
  endfunction

  // YX dimension order: resolve the row first, then the column.
  function automatic logic [PW-1:0] yx_port(input logic [XW-1:0] x,
                                            input logic [YW-1:0] y);
    logic [PW-1:0] port;
    if (int'(y) < MY_YPOS)      port = PORT_NEG_Y;
    else if (int'(y) > MY_YPOS) port = PORT_POS_Y;
    else if (int'(x) > MY_XPOS) port = PORT_POS_X;
    else if (int'(x) < MY_XPOS) port = PORT_NEG_X;
    else                        port = PORT_LOCAL;
    return port;
  endfunction

  always_comb begin
    w_rdy          = (r_state == ST_RUN);
    w_init_last    = (int'(r_init_x) == XDIM - 1) && (int'(r_init_y) == YDIM - 1);
    w_cfg_in_range = (int'(bus.cfg_xpos) < XDIM) && (int'(bus.cfg_ypos) < YDIM);
    w_lk_in_range  = (int'(bus.lk_xpos) < XDIM) && (int'(bus.lk_ypos) < YDIM);
    // A reload request in the same cycle takes priority over the write.
    w_cfg_accept   = bus.cfg_we && w_rdy && !bus.init_req && w_cfg_in_range;
    w_init_idx     = entry_idx(r_init_x, r_init_y);
    w_cfg_idx      = entry_idx(bus.cfg_xpos, bus.cfg_ypos);
    w_lk_idx       = entry_idx(bus.lk_xpos, bus.lk_ypos);
  end

  // Init sequencer and table storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_INIT;
      r_init_x <= '0;
      r_init_y <= '0;
      for (int i = 0; i < N; i++) begin
        r_table[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_INIT: begin
          if (bus.init_req) begin
            r_init_x <= '0;
            r_init_y <= '0;
          end else begin
            r_table[w_init_idx] <= yx_port(r_init_x, r_init_y);
            if (w_init_last) begin
              r_state  <= ST_RUN;
              r_init_x <= '0;
              r_init_y <= '0;
            end else if (int'(r_init_y) == YDIM - 1) begin
              r_init_y <= '0;
              r_init_x <= r_init_x + XW'(1);
            end else begin
              r_init_y <= r_init_y + YW'(1);
            end
          end
        end
        ST_RUN: begin
          if (bus.init_req) begin
            r_state  <= ST_INIT;
            r_init_x <= '0;
            r_init_y <= '0;
          end else if (w_cfg_accept) begin
            r_table[w_cfg_idx] <= bus.cfg_port;
          end
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  // Status pulses and registered lookup; result fields hold while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg_ack      <= 1'b0;
      r_cfg_err      <= 1'b0;
      r_lk_out_valid <= 1'b0;
      r_lk_port      <= '0;
      r_lk_err       <= 1'b0;
    end else begin
      r_cfg_ack      <= w_cfg_accept;
      r_cfg_err      <= bus.cfg_we && !w_cfg_accept;
      r_lk_out_valid <= bus.lk_valid;
      if (bus.lk_valid) begin
        if (w_rdy && w_lk_in_range) begin
          r_lk_port <= r_table[w_lk_idx];
          r_lk_err  <= 1'b0;
        end else begin
          r_lk_port <= PORT_INVALID;
          r_lk_err  <= 1'b1;
        end
      end
    end
  end

  assign bus.rdy          = w_rdy;
  assign bus.cfg_ack      = r_cfg_ack;
  assign bus.cfg_err      = r_cfg_err;
  assign bus.lk_out_valid = r_lk_out_valid;
  assign bus.lk_port      = r_lk_port;
  assign bus.lk_err       = r_lk_err;

endmodule
`default_nettype wire

// File: tb/tb_routing_table_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_routing_table_prog
// Description : Two tables (router (0,0) and router (2,1)) driven in lockstep,
//               checked against constant vectors and a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_routing_table_prog;

  localparam int XDIM = 5;
  localparam int YDIM = 4;
  localparam int XW   = 3;
  localparam int YW   = 3;
  localparam int PW   = 3;
  localparam int N    = XDIM * YDIM;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          init_req = 1'b0;
  logic          cfg_we   = 1'b0;
  logic [XW-1:0] cfg_x    = '0;
  logic [YW-1:0] cfg_y    = '0;
  logic [PW-1:0] cfg_port = '0;
  logic          lk_valid = 1'b0;
  logic [XW-1:0] lk_x     = '0;
  logic [YW-1:0] lk_y     = '0;

  routing_table_prog_if #(.XW(XW), .YW(YW), .PW(PW)) if0 ();
  routing_table_prog_if #(.XW(XW), .YW(YW), .PW(PW)) if1 ();

  assign if0.init_req = init_req;  assign if1.init_req = init_req;
  assign if0.cfg_we   = cfg_we;    assign if1.cfg_we   = cfg_we;
  assign if0.cfg_xpos = cfg_x;     assign if1.cfg_xpos = cfg_x;
  assign if0.cfg_ypos = cfg_y;     assign if1.cfg_ypos = cfg_y;
  assign if0.cfg_port = cfg_port;  assign if1.cfg_port = cfg_port;
  assign if0.lk_valid = lk_valid;  assign if1.lk_valid = lk_valid;
  assign if0.lk_xpos  = lk_x;      assign if1.lk_xpos  = lk_x;
  assign if0.lk_ypos  = lk_y;      assign if1.lk_ypos  = lk_y;

  routing_table_prog #(.XDIM(XDIM), .YDIM(YDIM), .XW(XW), .YW(YW), .PW(PW),
                       .MY_XPOS(0), .MY_YPOS(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  routing_table_prog #(.XDIM(XDIM), .YDIM(YDIM), .XW(XW), .YW(YW), .PW(PW),
                       .MY_XPOS(2), .MY_YPOS(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  // {rdy, cfg_ack, cfg_err, lk_out_valid, lk_port[2:0], lk_err}
  logic [7:0] obs [2];
  assign obs[0] = {if0.rdy, if0.cfg_ack, if0.cfg_err, if0.lk_out_valid, if0.lk_port, if0.lk_err};
  assign obs[1] = {if1.rdy, if1.cfg_ack, if1.cfg_err, if1.lk_out_valid, if1.lk_port, if1.lk_err};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Behavioural model: table contents, cycles left until ready, expected outputs.
  int mdl [2][8][8];
  int busy;
  int e_ack, e_err, e_ov;
  int e_port [2];
  int e_lerr [2];

  typedef struct {
    int x;
    int y;
    int p0;
    int p1;
  } lk_vec_t;
  lk_vec_t vecs [8];

  function automatic int yx_ref(input int mx, input int my, input int x, input int y);
    if (y < my) return 0;
    if (y > my) return 2;
    if (x > mx) return 1;
    if (x < mx) return 3;
    return 4;
  endfunction

  task automatic load_defaults();
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) begin
        mdl[0][x][y] = yx_ref(0, 0, x, y);
        mdl[1][x][y] = yx_ref(2, 1, x, y);
      end
  endtask

  task automatic model_reset();
    busy = N;
    e_ack = 0; e_err = 0; e_ov = 0;
    for (int d = 0; d < 2; d++) begin e_port[d] = 0; e_lerr[d] = 0; end
    load_defaults();
  endtask

  task automatic model_edge();
    bit rdy_now, lk_in, cfg_in;
    rdy_now = (busy == 0);
    lk_in   = (int'(lk_x) < XDIM) && (int'(lk_y) < YDIM);
    cfg_in  = (int'(cfg_x) < XDIM) && (int'(cfg_y) < YDIM);
    e_ack   = (rdy_now && cfg_we && !init_req && cfg_in) ? 1 : 0;
    e_err   = (cfg_we && e_ack == 0) ? 1 : 0;
    e_ov    = int'(lk_valid);
    if (lk_valid) begin
      for (int d = 0; d < 2; d++) begin
        if (rdy_now && lk_in) begin
          e_port[d] = mdl[d][lk_x][lk_y];
          e_lerr[d] = 0;
        end else begin
          e_port[d] = 7;
          e_lerr[d] = 1;
        end
      end
    end
    if (e_ack != 0) begin
      for (int d = 0; d < 2; d++) mdl[d][cfg_x][cfg_y] = int'(cfg_port);
    end
    if (init_req) begin
      busy = N;
      load_defaults();
    end else if (busy > 0) begin
      busy--;
    end
  endtask

  function automatic int exp_vec(input int d);
    return ((busy == 0) ? 128 : 0) + e_ack * 64 + e_err * 32 + e_ov * 16
           + e_port[d] * 2 + e_lerr[d];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    if (!rst) model_edge();
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++)
      check($sformatf("outs_c%0d_d%0d", cyc, d), int'(obs[d]), exp_vec(d));
  endtask

  task automatic lookup(input string name, input int x, input int y,
                        input int p0, input int p1, input int er);
    lk_valid = 1'b1;
    lk_x     = XW'(x);
    lk_y     = YW'(y);
    tick();
    check({name, "_port0"}, int'(obs[0][3:1]), p0);
    check({name, "_port1"}, int'(obs[1][3:1]), p1);
    check({name, "_err0"},  int'(obs[0][0]), er);
    check({name, "_err1"},  int'(obs[1][0]), er);
  endtask

  task automatic cfg_write(input string name, input int x, input int y, input int p,
                           input int ack, input int err);
    cfg_we   = 1'b1;
    cfg_x    = XW'(x);
    cfg_y    = YW'(y);
    cfg_port = PW'(p);
    tick();
    cfg_we   = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_ack%0d", name, d), int'(obs[d][6]), ack);
      check($sformatf("%s_err%0d", name, d), int'(obs[d][5]), err);
    end
  endtask

  // Expects the init sequence to have just begun; rdy must rise on tick 'total'.
  task automatic expect_rdy_after(input string name, input int done, input int total);
    for (int i = done; i < total - 1; i++) tick();
    for (int d = 0; d < 2; d++) check($sformatf("%s_pre%0d", name, d), int'(obs[d][7]), 0);
    tick();
    for (int d = 0; d < 2; d++) check($sformatf("%s_rise%0d", name, d), int'(obs[d][7]), 1);
  endtask

  initial begin
    vecs[0] = '{0, 0, 4, 0};
    vecs[1] = '{3, 0, 1, 0};
    vecs[2] = '{2, 3, 2, 2};
    vecs[3] = '{4, 3, 2, 2};
    vecs[4] = '{0, 1, 2, 3};
    vecs[5] = '{4, 1, 2, 1};
    vecs[6] = '{2, 1, 2, 4};
    vecs[7] = '{1, 0, 1, 0};

    // Reset: outputs cleared asynchronously, then 20 init cycles after release.
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) check($sformatf("rst_outs%0d", d), int'(obs[d]), 0);
    tick();
    tick();
    rst = 1'b0;
    expect_rdy_after("rdy_boot", 0, N);

    // Default routes for both routers, back-to-back lookups.
    foreach (vecs[i]) lookup($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].p0, vecs[i].p1, 0);
    lk_valid = 1'b0;
    tick();
    check("hold_valid", int'(obs[0][4]), 0);
    check("hold_port", int'(obs[0][3:1]), vecs[7].p0);

    for (int x = 0; x < XDIM; x++)
      for (int y = 0; y < YDIM; y++)
        lookup($sformatf("sweep_%0d_%0d", x, y), x, y, yx_ref(0, 0, x, y), yx_ref(2, 1, x, y), 0);
    lk_valid = 1'b0;
    tick();

    // Programming, and write/lookup collision returns the old entry.
    cfg_write("wr32", 3, 2, 3, 1, 0);
    lookup("rd32", 3, 2, 3, 3, 0);
    lk_valid = 1'b0;
    cfg_we = 1'b1; cfg_x = 3'd1; cfg_y = 3'd2; cfg_port = 3'd5;
    lk_valid = 1'b1; lk_x = 3'd1; lk_y = 3'd2;
    tick();
    cfg_we = 1'b0;
    check("coll_old0", int'(obs[0][3:1]), 2);
    check("coll_old1", int'(obs[1][3:1]), 2);
    check("coll_ack", int'(obs[0][6]), 1);
    lookup("coll_new", 1, 2, 5, 5, 0);
    lk_valid = 1'b0;

    // Out-of-range writes and lookups.
    cfg_write("wr50", 5, 0, 6, 0, 1);
    cfg_write("wr04", 0, 4, 6, 0, 1);
    lookup("rd73", 7, 3, 7, 7, 1);
    lookup("rd04", 0, 4, 7, 7, 1);
    lookup("rd00", 0, 0, 4, 0, 0);
    lk_valid = 1'b0;

    // Reload request beats a concurrent write; table unusable while reloading.
    init_req = 1'b1;
    cfg_write("wr_init", 3, 2, 1, 0, 1);
    init_req = 1'b0;
    check("init_rdy_drop", int'(obs[0][7]), 0);
    lookup("rd_init", 0, 0, 7, 7, 1);
    lk_valid = 1'b0;
    cfg_write("wr_busy", 0, 0, 5, 0, 1);
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    expect_rdy_after("rdy_restart", 0, N);
    lookup("rd32_dflt", 3, 2, 2, 2, 0);
    lookup("rd12_dflt", 1, 2, 2, 2, 0);
    lk_valid = 1'b0;

    // Reset in the middle of a reload loses a programmed entry.
    cfg_write("wr40", 4, 0, 6, 1, 0);
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    lookup("rd_mid", 1, 1, 7, 7, 1);
    lk_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) check($sformatf("rst_mid%0d", d), int'(obs[d]), 0);
    tick();
    rst = 1'b0;
    expect_rdy_after("rdy_rst", 0, N);
    lookup("rd40_lost", 4, 0, 1, 0, 0);
    lk_valid = 1'b0;

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      init_req = ($urandom_range(0, 79) == 0);
      cfg_we   = ($urandom_range(0, 2) == 0);
      cfg_x    = XW'($urandom_range(0, 6));
      cfg_y    = YW'($urandom_range(0, 5));
      cfg_port = PW'($urandom);
      lk_valid = (i == 0) || ($urandom_range(0, 1) == 1);
      lk_x     = XW'($urandom_range(0, 6));
      lk_y     = YW'($urandom_range(0, 5));
      tick();
    end
    init_req = 1'b0;
    cfg_we   = 1'b0;
    lk_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
